// File: rtl/pacman_pkg.sv
// Shared types and helpers for the sprite movement / wall-probe logic.
// WALL_PROBE_MID_EN adds the PROBE_M state (leading-edge midpoint probe).
package pacman_pkg;

  localparam int SPRITE_SIZE_D = 16;
  localparam int STEP_D        = 1;
  localparam int COORD_W       = 10;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE,
    PROBE_A,
    PROBE_B,
    RESP
`ifdef WALL_PROBE_MID_EN
    , PROBE_M
`endif
  } probe_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  // Addition clamps at 1023, which lies in the map's outer-bound region.
  function automatic logic [COORD_W-1:0] sat_add(input logic [COORD_W-1:0] a,
                                                 input logic [10:0] b);
    logic [11:0] s;
    s = {2'b00, a} + {1'b0, b};
    return (s > 12'd1023) ? '1 : COORD_W'(s);
  endfunction

  // Subtraction clamps at 0, also inside the outer-bound region.
  function automatic logic [COORD_W-1:0] sat_sub(input logic [COORD_W-1:0] a,
                                                 input logic [10:0] b);
    logic [10:0] ext;
    ext = {1'b0, a};
    return (ext < b) ? '0 : COORD_W'(ext - b);
  endfunction

  // Leading-edge probe point: 'off' runs along the edge, 'lead' is the
  // far-side distance (size-1+step) and 'step' the near-side distance.
  function automatic coord_t probe_point(input logic [COORD_W-1:0] x,
                                         input logic [COORD_W-1:0] y,
                                         input dir_t d,
                                         input logic [10:0] off,
                                         input logic [10:0] lead,
                                         input logic [10:0] step);
    coord_t p;
    case (d)
      UP:      begin p.x = sat_add(x, off);  p.y = sat_sub(y, step); end
      DOWN:    begin p.x = sat_add(x, off);  p.y = sat_add(y, lead); end
      LEFT:    begin p.x = sat_sub(x, step); p.y = sat_add(y, off);  end
      default: begin p.x = sat_add(x, lead); p.y = sat_add(y, off);  end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 5,
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   grant,
  output logic               valid
);

  int unsigned idx;

  // Scan NUM_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (!valid && req[idx]) begin
        grant = PTR_W'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wall_probe_arbiter.sv
// Shares one combinational wall-map lookup among NUM_REQ sprite movers.
// Each granted request probes the two leading-edge corners one per cycle,
// plus the edge midpoint when WALL_PROBE_MID_EN is defined.
module wall_probe_arbiter
  import pacman_pkg::*;
#(
  parameter int NUM_REQ     = 5,
  parameter int SPRITE_SIZE = SPRITE_SIZE_D,
  parameter int STEP        = STEP_D
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic [NUM_REQ-1:0]         Req,
  input  logic [NUM_REQ*COORD_W-1:0] PosX,
  input  logic [NUM_REQ*COORD_W-1:0] PosY,
  input  logic [NUM_REQ*2-1:0]       Dir,
  output logic [NUM_REQ-1:0]         Ack,
  output logic [NUM_REQ-1:0]         Blocked,
  output logic [COORD_W-1:0]         ProbeX,
  output logic [COORD_W-1:0]         ProbeY,
  input  logic                       WallHit
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [10:0] LEAD   = 11'(SPRITE_SIZE - 1 + STEP);
  localparam logic [10:0] STEP_L = 11'(STEP);
  localparam logic [10:0] EDGE   = 11'(SPRITE_SIZE - 1);
  localparam logic [10:0] MID    = 11'((SPRITE_SIZE - 1) / 2);

  probe_state_t       state, state_next;
  logic [PTR_W-1:0]   rr_ptr, g, arb_grant;
  logic               arb_valid;
  logic [COORD_W-1:0] lx, ly;
  dir_t               ldir;
  logic               hit_a, hit_b;
`ifdef WALL_PROBE_MID_EN
  logic               hit_m;
`endif
  logic [NUM_REQ-1:0] blocked_q;
  logic               result;
  coord_t             probe;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req  (Req),
    .ptr  (rr_ptr),
    .grant(arb_grant),
    .valid(arb_valid)
  );

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state and the probe coordinate driven to the shared lookup.
  always_comb begin
    state_next = state;
    probe      = '0;
    case (state)
      IDLE:    if (arb_valid) state_next = PROBE_A;
      PROBE_A: begin
        probe      = probe_point(lx, ly, ldir, 11'd0, LEAD, STEP_L);
        state_next = PROBE_B;
      end
      PROBE_B: begin
        probe      = probe_point(lx, ly, ldir, EDGE, LEAD, STEP_L);
`ifdef WALL_PROBE_MID_EN
        state_next = PROBE_M;
`else
        state_next = RESP;
`endif
      end
`ifdef WALL_PROBE_MID_EN
      PROBE_M: begin
        probe      = probe_point(lx, ly, ldir, MID, LEAD, STEP_L);
        state_next = RESP;
      end
`endif
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ProbeX = probe.x;
  assign ProbeY = probe.y;

  // Combined verdict from the registered probe hits.
  always_comb begin
`ifdef WALL_PROBE_MID_EN
    result = hit_a | hit_b | hit_m;
`else
    result = hit_a | hit_b;
`endif
  end

  // The fresh result bypasses blocked_q during RESP so it appears with Ack.
  always_comb begin
    Ack     = '0;
    Blocked = blocked_q;
    if (state == RESP) begin
      Ack[g]     = 1'b1;
      Blocked[g] = result;
    end
  end

  // Grant latching, probe hit capture, result commit and pointer advance.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_ptr    <= '0;
      g         <= '0;
      lx        <= '0;
      ly        <= '0;
      ldir      <= UP;
      hit_a     <= 1'b0;
      hit_b     <= 1'b0;
`ifdef WALL_PROBE_MID_EN
      hit_m     <= 1'b0;
`endif
      blocked_q <= '0;
    end else begin
      case (state)
        IDLE: if (arb_valid) begin
          g    <= arb_grant;
          lx   <= PosX[arb_grant*COORD_W +: COORD_W];
          ly   <= PosY[arb_grant*COORD_W +: COORD_W];
          ldir <= dir_t'(Dir[arb_grant*2 +: 2]);
        end
        PROBE_A: hit_a <= WallHit;
        PROBE_B: hit_b <= WallHit;
`ifdef WALL_PROBE_MID_EN
        PROBE_M: hit_m <= WallHit;
`endif
        RESP: begin
          blocked_q[g] <= result;
          rr_ptr       <= (g == PTR_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wall_probe_arbiter.sv
// Directed bench for wall_probe_arbiter with a small wall-map model on
// ProbeX/ProbeY. Expectations track WALL_PROBE_MID_EN when it is defined.
module tb_wall_probe_arbiter;
  import pacman_pkg::*;

  localparam int N = 5;

  logic           Clk = 1'b0;
  logic           Reset_n;
  logic [N-1:0]   Req;
  logic [N*10-1:0] PosX, PosY;
  logic [N*2-1:0] Dir;
  logic [N-1:0]   Ack, Blocked;
  logic [9:0]     ProbeX, ProbeY;
  logic           WallHit;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  wall_probe_arbiter #(.NUM_REQ(N), .SPRITE_SIZE(16), .STEP(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .PosX(PosX), .PosY(PosY),
    .Dir(Dir), .Ack(Ack), .Blocked(Blocked), .ProbeX(ProbeX),
    .ProbeY(ProbeY), .WallHit(WallHit)
  );

  // Wall map: outer bound, square1, and the 2-pixel-wide T1 stick.
  always_comb begin
    WallHit = (ProbeX < 10'd8) || (ProbeX > 10'd631) ||
              (ProbeY < 10'd51) || (ProbeY > 10'd470) ||
              (ProbeX >= 10'd191 && ProbeX <= 10'd240 &&
               ProbeY >= 10'd64 && ProbeY <= 10'd112) ||
              (ProbeX >= 10'd321 && ProbeX <= 10'd322 &&
               ProbeY >= 10'd164 && ProbeY <= 10'd170);
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One isolated request; position is scrambled after the grant edge.
  task automatic run_txn(input int idx, input logic [9:0] x, input logic [9:0] y,
                         input logic [1:0] d,
                         input logic [9:0] ax, input logic [9:0] ay,
                         input logic [9:0] bx, input logic [9:0] by,
                         input logic [9:0] mx, input logic [9:0] my,
                         input logic blk, input string tag);
    PosX[idx*10 +: 10] = x;
    PosY[idx*10 +: 10] = y;
    Dir[idx*2 +: 2]    = d;
    Req                = '0;
    Req[idx]           = 1'b1;
    step();
    Req = '0;
    PosX[idx*10 +: 10] = 10'd0;
    PosY[idx*10 +: 10] = 10'd0;
    chk({tag, "_ack_a"}, 32'(Ack), 0);
    chk({tag, "_ax"}, 32'(ProbeX), 32'(ax));
    chk({tag, "_ay"}, 32'(ProbeY), 32'(ay));
    step();
    chk({tag, "_ack_b"}, 32'(Ack), 0);
    chk({tag, "_bx"}, 32'(ProbeX), 32'(bx));
    chk({tag, "_by"}, 32'(ProbeY), 32'(by));
`ifdef WALL_PROBE_MID_EN
    step();
    chk({tag, "_ack_m"}, 32'(Ack), 0);
    chk({tag, "_mx"}, 32'(ProbeX), 32'(mx));
    chk({tag, "_my"}, 32'(ProbeY), 32'(my));
`else
    if (mx != 10'd1023 || my != 10'd1023) checks = checks + 0;
`endif
    step();
    chk({tag, "_ack"}, 32'(Ack), 32'(1) << idx);
    chk({tag, "_blk"}, 32'(Blocked[idx]), 32'(blk));
    chk({tag, "_px_resp"}, 32'(ProbeX), 0);
    step();
    chk({tag, "_ack_clr"}, 32'(Ack), 0);
    chk({tag, "_blk_hold"}, 32'(Blocked[idx]), 32'(blk));
  endtask

  initial begin
    int nprobe;
`ifdef WALL_PROBE_MID_EN
    nprobe = 3;
`else
    nprobe = 2;
`endif
    Reset_n = 1'b0;
    Req = '0; PosX = '0; PosY = '0; Dir = '0;
    step(); step();
    chk("rst_ack", 32'(Ack), 0);
    chk("rst_blk", 32'(Blocked), 0);
    chk("rst_px", 32'(ProbeX), 0);
    chk("rst_py", 32'(ProbeY), 0);
    Reset_n = 1'b1;
    step();

    // right from (174,80): far edge x=190 clear of square1 at 191
    run_txn(0, 10'd174, 10'd80, 2'd3, 10'd190, 10'd80, 10'd190, 10'd95,
            10'd190, 10'd87, 1'b0, "right_free");
    // one pixel further: x=191 lands on square1
    run_txn(0, 10'd175, 10'd80, 2'd3, 10'd191, 10'd80, 10'd191, 10'd95,
            10'd191, 10'd87, 1'b1, "right_sq1");
    // up from y=51 reaches y=50 (outer bound); from y=52 reaches free y=51
    run_txn(0, 10'd170, 10'd51, 2'd0, 10'd170, 10'd50, 10'd185, 10'd50,
            10'd177, 10'd50, 1'b1, "up_bound");
    run_txn(0, 10'd170, 10'd52, 2'd0, 10'd170, 10'd51, 10'd185, 10'd51,
            10'd177, 10'd51, 1'b0, "up_free");
    // left from x=0 saturates to 0
    run_txn(1, 10'd0, 10'd200, 2'd2, 10'd0, 10'd200, 10'd0, 10'd215,
            10'd0, 10'd207, 1'b1, "left_sat");
    // down near the bottom saturates to 1023
    run_txn(2, 10'd500, 10'd1015, 2'd1, 10'd500, 10'd1023, 10'd515, 10'd1023,
            10'd507, 10'd1023, 1'b1, "down_sat");
    // stick at x 321..322, y 164..170 only seen by the midpoint probe
`ifdef WALL_PROBE_MID_EN
    run_txn(3, 10'd305, 10'd160, 2'd3, 10'd321, 10'd160, 10'd321, 10'd175,
            10'd321, 10'd167, 1'b1, "stick");
`else
    run_txn(3, 10'd305, 10'd160, 2'd3, 10'd321, 10'd160, 10'd321, 10'd175,
            10'd321, 10'd167, 1'b0, "stick");
`endif

    // reset during PROBE_A clears Blocked (set by left_sat) and drops the Ack
    PosX[9:0] = 10'd175; PosY[9:0] = 10'd80; Dir[1:0] = 2'd3;
    Req = 5'b00001;
    step();
    chk("mid_rst_pa_x", 32'(ProbeX), 191);
    #2 Reset_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
    chk("mid_rst_ack", 32'(Ack), 0);
    chk("mid_rst_blk", 32'(Blocked), 0);
    chk("mid_rst_px", 32'(ProbeX), 0);
    chk("mid_rst_py", 32'(ProbeY), 0);
    Req = '0;
    step();
    chk("mid_rst_ack2", 32'(Ack), 0);
    Reset_n = 1'b1;
    step();

    // all requesters held: service order 0,1,2,3,4,0 with fixed spacing
    for (int i = 0; i < N; i++) begin
      PosX[i*10 +: 10] = 10'(400 + 20 * i);
      PosY[i*10 +: 10] = 10'd300;
      Dir[i*2 +: 2]    = 2'd1;
    end
    Req = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      for (int s = 0; s < nprobe + 1; s++) step();
      chk($sformatf("rr_ack%0d", k), 32'(Ack), 32'(1) << (k % N));
      chk($sformatf("rr_blk%0d", k), 32'(Blocked), 0);
      step();
      chk($sformatf("rr_gap%0d", k), 32'(Ack), 0);
    end
    Req = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
